// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared constants and the refill FSM state type for the L1 refill controller.
//   LINE_WORDS    words per cache line
//   OFFSET_W      byte-offset bits inside a word
//   WORD_SEL_W    word-select bits inside a line
//   COUNTER_DONE  counter value telling the cache the line is complete
package cache_pkg;

    localparam int         LINE_WORDS   = 4;
    localparam int         OFFSET_W     = 2;
    localparam int         WORD_SEL_W   = 2;
    localparam logic [2:0] COUNTER_DONE = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/write_buffer_1e.sv
// write_buffer_1e
//   One-entry write-through buffer between cache store hits and memory.
//   clk, rst         clock / async active-high reset (entry is dropped on reset)
//   cpu_write_i      store request
//   cpu_addr_i       word address of the store (byte offset already stripped)
//   cpu_wdata_i      store data
//   drain_i          memory accepted the buffered write, free the entry
//   wb_valid_o       entry occupied
//   wb_addr_o        buffered word address
//   wb_data_o        buffered data
//   wr_stall_o       store presented while the entry is occupied (not captured)
module write_buffer_1e #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_write_i,
    input  logic [ADDR_W-cache_pkg::OFFSET_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0]               cpu_wdata_i,
    input  logic                            drain_i,
    output logic                            wb_valid_o,
    output logic [ADDR_W-cache_pkg::OFFSET_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0]               wb_data_o,
    output logic                            wr_stall_o
);
    import cache_pkg::*;

    logic                         wb_valid_q, wb_valid_d;
    logic [ADDR_W-OFFSET_W-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]            wb_data_q, wb_data_d;
    logic                         capture;

    assign capture = cpu_write_i & ~wb_valid_q;

    // drain only happens while the entry is full, so it never collides with capture
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (capture) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = cpu_addr_i;
            wb_data_d  = cpu_wdata_i;
        end else if (drain_i) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_addr_o  = wb_addr_q;
    assign wb_data_o  = wb_data_q;
    assign wr_stall_o = cpu_write_i & wb_valid_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Memory-side partner of the direct-mapped L1: refills a 4-word line on a read
//   miss (one word per ack, reported through memory_word_o/counter_o) and drains
//   store hits to memory through a one-entry write-through buffer.
//   clk, rst                 clock / async active-high reset
//   cpu_addr_i, cpu_wdata_i  CPU byte address and store data
//   cpu_write_i, miss_i      store request, cache read miss
//   memory_word_o, counter_o refill word and its index (4 = line complete)
//   wr_stall_o, busy_o       store blocked / controller or buffer active
//   mem_req_o .. mem_wdata_o memory request port, held until mem_ack_i
//   mem_ack_i, mem_rdata_i   memory acknowledge and read data
//
//   state | meaning
//   IDLE  | waiting; buffered write has priority over a refill
//   WR    | draining the write buffer to memory
//   RD    | fetching word k of the line
//   DONE  | last word delivered; counter goes to 4 next
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              cpu_write_i,
    input  logic              miss_i,
    output logic [DATA_W-1:0] memory_word_o,
    output logic [2:0]        counter_o,
    output logic              wr_stall_o,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    localparam int LINE_LSB = OFFSET_W + WORD_SEL_W;
    localparam logic [WORD_SEL_W-1:0] LAST_WORD = WORD_SEL_W'(LINE_WORDS - 1);

    refill_state_e                state_q, state_d;
    logic [WORD_SEL_W-1:0]        k_q, k_d;
    logic [ADDR_W-1:LINE_LSB]     line_addr_q, line_addr_d;
    logic [2:0]                   counter_q, counter_d;
    logic [DATA_W-1:0]            memory_word_q, memory_word_d;

    logic                         wb_valid;
    logic [ADDR_W-OFFSET_W-1:0]   wb_addr;
    logic [DATA_W-1:0]            wb_data;
    logic                         wb_drain;
    logic                         addr_lsb_unused;

    assign addr_lsb_unused = ^cpu_addr_i[OFFSET_W-1:0];

    write_buffer_1e #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wb (
        .clk         (clk),
        .rst         (rst),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i[ADDR_W-1:OFFSET_W]),
        .cpu_wdata_i (cpu_wdata_i),
        .drain_i     (wb_drain),
        .wb_valid_o  (wb_valid),
        .wb_addr_o   (wb_addr),
        .wb_data_o   (wb_data),
        .wr_stall_o  (wr_stall_o)
    );

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        line_addr_d   = line_addr_q;
        counter_d     = counter_q;
        memory_word_d = memory_word_q;
        wb_drain      = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        case (state_q)
            IDLE: begin
                counter_d = '0;
                // while counter shows 4 the cache is still committing the line, so
                // its miss line has not dropped yet and must not start a new refill
                if (wb_valid) begin
                    state_d = WR;
                end else if (miss_i && !cpu_write_i && (counter_q != COUNTER_DONE)) begin
                    state_d     = RD;
                    line_addr_d = cpu_addr_i[ADDR_W-1:LINE_LSB];
                    k_d         = '0;
                end
            end
            WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {wb_addr, {OFFSET_W{1'b0}}};
                mem_wdata_o = wb_data;
                if (mem_ack_i) begin
                    wb_drain = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {line_addr_q, k_q, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    memory_word_d = mem_rdata_i;
                    counter_d     = {1'b0, k_q};
                    if (k_q == LAST_WORD) state_d = DONE;
                    else                  k_d     = k_q + WORD_SEL_W'(1);
                end
            end
            DONE: begin
                counter_d = COUNTER_DONE;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            line_addr_q   <= '0;
            counter_q     <= '0;
            memory_word_q <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            line_addr_q   <= line_addr_d;
            counter_q     <= counter_d;
            memory_word_q <= memory_word_d;
        end
    end

    assign memory_word_o = memory_word_q;
    assign counter_o     = counter_q;
    assign busy_o        = (state_q != IDLE) | wb_valid;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_write, miss;
    logic [31:0] memory_word;
    logic [2:0]  counter;
    logic        wr_stall, busy, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    cache_refill_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_addr_i    (cpu_addr),
        .cpu_wdata_i   (cpu_wdata),
        .cpu_write_i   (cpu_write),
        .miss_i        (miss),
        .memory_word_o (memory_word),
        .counter_o     (counter),
        .wr_stall_o    (wr_stall),
        .busy_o        (busy),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata)
    );

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct packed { logic [2:0] cnt; logic [31:0] word; } fill_t;
    typedef struct { logic [31:0] addr; int lat; logic [31:0] last_word; } vec_t;

    req_t        exp_req[$];
    fill_t       exp_fill[$];
    logic [31:0] ref_mem  [0:255];
    logic [31:0] phys_mem [0:255];
    int          compared   = 0;
    int          mismatched = 0;
    int          lat = 0;
    int          cyc = 0;
    int          fill_cyc [0:3];
    int          done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // memory responder: acks after 'lat' waiting cycles, junk on rdata otherwise
    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (wcnt >= lat) begin
                    mem_ack = 1'b1;
                    if (mem_we) phys_mem[mem_addr[9:2]] = mem_wdata;
                    else        mem_rdata = phys_mem[mem_addr[9:2]];
                    wcnt = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'hBAD0_0000 | 32'(wcnt);
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    // monitor: request scoreboard, refill word scoreboard, request stability
    initial begin
        bit          pend, rd_ack_prev;
        int          done_phase;
        logic [31:0] pend_addr;
        req_t        r;
        fill_t       f;
        pend = 0; rd_ack_prev = 0; done_phase = 0; pend_addr = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend = 0; rd_ack_prev = 0; done_phase = 0;
            end else begin
                if (pend) begin
                    check("req_held", {31'h0, mem_req}, 32'd1);
                    check("addr_held", mem_addr, pend_addr);
                end
                if (done_phase == 1) begin
                    check("counter_done", {29'h0, counter}, 32'd4);
                    done_cyc   = cyc;
                    done_phase = 2;
                end else if (done_phase == 2) begin
                    check("counter_clear", {29'h0, counter}, 32'd0);
                    done_phase = 0;
                end
                if (rd_ack_prev) begin
                    if (exp_fill.size() == 0) fail_now("unexpected_fill_word");
                    else begin
                        f = exp_fill.pop_front();
                        check("fill_counter", {29'h0, counter}, {29'h0, f.cnt});
                        check("fill_word", memory_word, f.word);
                        fill_cyc[f.cnt[1:0]] = cyc;
                        if (f.cnt == 3'd3) done_phase = 1;
                    end
                end
                if (mem_req && mem_ack) begin
                    if (exp_req.size() == 0) fail_now("unexpected_request");
                    else begin
                        r = exp_req.pop_front();
                        check("req_we", {31'h0, mem_we}, {31'h0, r.we});
                        check("req_addr", mem_addr, r.addr);
                        if (r.we) check("req_wdata", mem_wdata, r.wdata);
                    end
                end
                pend        = mem_req && !mem_ack;
                pend_addr   = mem_addr;
                rd_ack_prev = mem_req && mem_ack && !mem_we;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_refill(input logic [31:0] a);
        logic [31:0] wa;
        logic [1:0]  kk;
        for (int k = 0; k < 4; k++) begin
            kk = 2'(k);
            wa = {a[31:4], kk, 2'b00};
            exp_req.push_back('{1'b0, wa, 32'h0});
            exp_fill.push_back('{{1'b0, kk}, ref_mem[wa[9:2]]});
        end
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d);
        exp_req.push_back('{1'b1, {a[31:2], 2'b00}, d});
        ref_mem[a[9:2]] = d;
    endtask

    // wait for counter==4, then release miss as the cache would
    task automatic wait_done(input bit chk_busy);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (chk_busy && mem_req) check("busy_during_op", {31'h0, busy}, 32'd1);
            if (counter == 3'd4) break;
            n++;
            if (n > 300) begin
                fail_now("timeout_wait_counter4");
                break;
            end
        end
        step();
        miss = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_req.size() != 0 || busy) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) fail_now("timeout_drain");
    endtask

    vec_t vecs [0:4];

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            if (i >= 8'h50 && i <= 8'h53) phys_mem[i] = 32'h0000_00A0 + 32'(i - 8'h50);
            else                          phys_mem[i] = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = phys_mem[i];
        end
        vecs[0] = '{32'h0000_0140, 2, 32'h0000_00A3};
        vecs[1] = '{32'h0000_02F4, 0, 32'hC0DE_00BF};
        vecs[2] = '{32'h0000_03A8, 1, 32'hC0DE_00EB};
        vecs[3] = '{32'h0000_0018, 3, 32'hC0DE_0007};
        vecs[4] = '{32'h8000_0144, 1, 32'h0000_00A3};

        cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_write = 1'b1; miss = 1'b0;
        #12;
        check("rst_mem_req", {31'h0, mem_req}, 32'd0);
        check("rst_counter", {29'h0, counter}, 32'd0);
        check("rst_memory_word", memory_word, 32'd0);
        check("rst_wr_stall", {31'h0, wr_stall}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        cpu_write = 1'b0;
        step();
        rst = 1'b0;
        step();

        // line refills over several latencies and addresses
        for (int i = 0; i < 5; i++) begin
            lat = vecs[i].lat;
            push_refill(vecs[i].addr);
            cpu_addr = vecs[i].addr;
            miss     = 1'b1;
            wait_done(1'b0);
            check("last_word", memory_word, vecs[i].last_word);
            if (vecs[i].lat == 0) begin
                for (int k = 1; k < 4; k++)
                    check("zero_wait_gap", 32'(fill_cyc[k] - fill_cyc[k-1]), 32'd1);
                check("zero_wait_done_gap", 32'(done_cyc - fill_cyc[3]), 32'd1);
            end
            step();
        end

        // store, then a second store stalled until the buffer drains
        lat = 3;
        cpu_addr = 32'h0000_0100; cpu_wdata = 32'hDEAD_BEEF; cpu_write = 1'b1;
        push_store(32'h0000_0100, 32'hDEAD_BEEF);
        @(negedge clk);
        check("store1_no_stall", {31'h0, wr_stall}, 32'd0);
        check("store1_busy_before", {31'h0, busy}, 32'd0);
        step();
        cpu_addr = 32'h0000_0104; cpu_wdata = 32'h1234_5678;
        @(negedge clk);
        check("store2_stall", {31'h0, wr_stall}, 32'd1);
        check("store2_busy", {31'h0, busy}, 32'd1);
        n = 0;
        forever begin
            @(negedge clk);
            if (!wr_stall) break;
            n++;
            if (n > 100) begin
                fail_now("timeout_store2_stall");
                break;
            end
        end
        push_store(32'h0000_0104, 32'h1234_5678);
        step();
        cpu_write = 1'b0;
        drain();

        // pending store then a miss to the same line: write goes first
        lat = 1;
        cpu_addr = 32'h0000_0100; cpu_wdata = 32'h1111_2222; cpu_write = 1'b1;
        push_store(32'h0000_0100, 32'h1111_2222);
        step();
        cpu_write = 1'b0;
        miss      = 1'b1;
        push_refill(32'h0000_0100);
        wait_done(1'b1);
        step();

        // store in the same cycle as the miss: refill deferred behind the drain
        lat = 2;
        cpu_addr = 32'h0000_01C0; cpu_wdata = 32'h5A5A_5A5A; cpu_write = 1'b1; miss = 1'b1;
        push_store(32'h0000_01C0, 32'h5A5A_5A5A);
        push_refill(32'h0000_01C0);
        step();
        cpu_write = 1'b0;
        @(negedge clk);
        check("same_cycle_busy", {31'h0, busy}, 32'd1);
        wait_done(1'b1);
        step();

        // reset while word 2 is outstanding, miss held: restart from word 0
        lat = 3;
        cpu_addr = 32'h0000_0240;
        push_refill(32'h0000_0240);
        miss = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            #2;
            if (exp_req.size() == 2 && mem_req && !mem_ack) break;
            n++;
            if (n > 100) begin
                fail_now("timeout_reach_word2");
                break;
            end
        end
        rst = 1'b1;
        #1;
        check("midrst_mem_req", {31'h0, mem_req}, 32'd0);
        check("midrst_counter", {29'h0, counter}, 32'd0);
        check("midrst_memory_word", memory_word, 32'd0);
        check("midrst_busy", {31'h0, busy}, 32'd0);
        exp_req.delete();
        exp_fill.delete();
        step();
        step();
        rst = 1'b0;
        push_refill(32'h0000_0240);
        wait_done(1'b1);
        drain();

        check("req_queue_empty", 32'(exp_req.size()), 32'd0);
        check("fill_queue_empty", 32'(exp_fill.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
